// File: rtl/serial_nibble_sorter.sv
// Streaming four-element sorter: loads four nibbles over valid/ready, sorts them in
// place with one compare-exchange unit over five cycles, then streams them back out.
module serial_nibble_sorter #(
  parameter int WIDTH   = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_slot [4];
  logic [1:0]       r_idx;
  logic [2:0]       r_step;

  logic             w_inFire;
  logic             w_outFire;
  logic [1:0]       w_pairA;
  logic [1:0]       w_pairB;
  logic             w_swap;

  // Handshake-visible outputs come only from registered state and index.
  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == EMIT);
  assign out_last  = (r_state == EMIT) && (r_idx == 2'd3);
  assign out_data  = (r_state == EMIT) ? r_slot[r_idx] : '0;
  assign busy      = (r_state != LOAD);

  assign w_inFire  = in_valid && in_ready;
  assign w_outFire = out_valid && out_ready;

  // Five-step network (0,2)(1,3)(0,1)(2,3)(1,2) fully sorts four elements.
  always_comb begin
    w_pairA = 2'd1;
    w_pairB = 2'd2;
    case (r_step)
      3'd0: begin w_pairA = 2'd0; w_pairB = 2'd2; end
      3'd1: begin w_pairA = 2'd1; w_pairB = 2'd3; end
      3'd2: begin w_pairA = 2'd0; w_pairB = 2'd1; end
      3'd3: begin w_pairA = 2'd2; w_pairB = 2'd3; end
      default: begin w_pairA = 2'd1; w_pairB = 2'd2; end
    endcase
    if (DESCEND)
      w_swap = (r_slot[w_pairA] < r_slot[w_pairB]);
    else
      w_swap = (r_slot[w_pairA] > r_slot[w_pairB]);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_state <= LOAD;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = LOAD;
    case (r_state)
      LOAD:    w_nextState = (w_inFire && (r_idx == 2'd3)) ? SORT : LOAD;
      SORT:    w_nextState = (r_step == 3'd4) ? EMIT : SORT;
      EMIT:    w_nextState = (w_outFire && (r_idx == 2'd3)) ? LOAD : EMIT;
      default: w_nextState = LOAD;
    endcase
  end

  // The 2-bit index wraps 3->0 exactly on the LOAD->SORT and EMIT->LOAD transitions.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 4; i++)
        r_slot[i] <= '0;
      r_idx  <= 2'd0;
      r_step <= 3'd0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_inFire) begin
            r_slot[r_idx] <= in_data;
            r_idx         <= r_idx + 2'd1;
            if (r_idx == 2'd3)
              r_step <= 3'd0;
          end
        end
        SORT: begin
          if (w_swap) begin
            r_slot[w_pairA] <= r_slot[w_pairB];
            r_slot[w_pairB] <= r_slot[w_pairA];
          end
          r_step <= r_step + 3'd1;
          if (r_step == 3'd4)
            r_idx <= 2'd0;
        end
        EMIT: begin
          if (w_outFire)
            r_idx <= r_idx + 2'd1;
        end
        default: begin
          r_idx  <= 2'd0;
          r_step <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_sorter.sv
// Directed bench for serial_nibble_sorter: ascending and descending instances share
// one input stream and one consumer, so both see identical handshake timing.
module tb_serial_nibble_sorter;

  typedef logic [3:0] group_t [4];

  logic       clk;
  logic       nrst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;
  logic       descInReady;
  logic       descOutValid;
  logic [3:0] descOutData;
  logic       descOutLast;
  logic       descBusy;

  int nCompared   = 0;
  int nMismatched = 0;

  serial_nibble_sorter #(.WIDTH(4), .DESCEND(1'b0)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  serial_nibble_sorter #(.WIDTH(4), .DESCEND(1'b1)) dutDesc (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (descInReady),
    .in_data   (in_data),
    .out_valid (descOutValid),
    .out_ready (out_ready),
    .out_data  (descOutData),
    .out_last  (descOutLast),
    .busy      (descBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input group_t vals, input int gap, input bit holdValid);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        checkOutput("loadIdleReady", 32'(in_ready), 32'd1);
        tick();
      end
      in_valid = 1'b1;
      in_data  = vals[i];
      checkOutput("loadReady", 32'(in_ready), 32'd1);
      checkOutput("loadNotBusy", 32'(busy), 32'd0);
      tick();
    end
    if (holdValid)
      in_data = 4'hE;
    else
      in_valid = 1'b0;
    checkOutput("readyDropAfterLoad", 32'(in_ready), 32'd0);
    checkOutput("busyAfterLoad", 32'(busy), 32'd1);
  endtask

  task automatic waitOutValid;
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      checkOutput("busyDuringSort", 32'(busy), 32'd1);
      checkOutput("readyDuringSort", 32'(in_ready), 32'd0);
      tick();
      cnt++;
    end
    checkOutput("firstOutLatency", 32'(cnt), 32'd5);
  endtask

  task automatic emitGroup(input group_t expAsc, input group_t expDesc,
                           input int stallFirst, input int stallLast);
    int stall;
    for (int i = 0; i < 4; i++) begin
      stall = (i == 0) ? stallFirst : ((i == 3) ? stallLast : 0);
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        checkOutput("stallValid", 32'(out_valid), 32'd1);
        checkOutput("stallData", 32'(out_data), 32'(expAsc[i]));
        checkOutput("stallLast", 32'(out_last), (i == 3) ? 32'd1 : 32'd0);
        checkOutput("stallReady", 32'(in_ready), 32'd0);
        tick();
      end
      if (i == 3)
        in_valid = 1'b0;
      out_ready = 1'b1;
      checkOutput("emitValid", 32'(out_valid), 32'd1);
      checkOutput("emitData", 32'(out_data), 32'(expAsc[i]));
      checkOutput("emitLast", 32'(out_last), (i == 3) ? 32'd1 : 32'd0);
      checkOutput("emitBusy", 32'(busy), 32'd1);
      checkOutput("emitReady", 32'(in_ready), 32'd0);
      checkOutput("descData", 32'(descOutData), 32'(expDesc[i]));
      checkOutput("descLast", 32'(descOutLast), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    checkOutput("readyAfterLast", 32'(in_ready), 32'd1);
    checkOutput("idleAfterLast", 32'(busy), 32'd0);
    checkOutput("validAfterLast", 32'(out_valid), 32'd0);
  endtask

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b1;
    #12;
    $display("[TB] checking reset state");
    checkOutput("rstReady", 32'(in_ready), 32'd1);
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstLast", 32'(out_last), 32'd0);
    checkOutput("rstData", 32'(out_data), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    tick();
    nrst = 1'b1;
    tick();

    $display("[TB] group 9,3,7,1 with in_valid held high");
    applyStimulus('{4'd9, 4'd3, 4'd7, 4'd1}, 0, 1'b1);
    waitOutValid();
    emitGroup('{4'd1, 4'd3, 4'd7, 4'd9}, '{4'd9, 4'd7, 4'd3, 4'd1}, 0, 0);

    $display("[TB] duplicates 5,5,2,5");
    applyStimulus('{4'd5, 4'd5, 4'd2, 4'd5}, 0, 1'b0);
    waitOutValid();
    emitGroup('{4'd2, 4'd5, 4'd5, 4'd5}, '{4'd5, 4'd5, 4'd5, 4'd2}, 0, 0);

    $display("[TB] all-zero group then 15,0,15,0");
    applyStimulus('{4'd0, 4'd0, 4'd0, 4'd0}, 0, 1'b0);
    waitOutValid();
    emitGroup('{4'd0, 4'd0, 4'd0, 4'd0}, '{4'd0, 4'd0, 4'd0, 4'd0}, 0, 0);
    applyStimulus('{4'd15, 4'd0, 4'd15, 4'd0}, 0, 1'b0);
    waitOutValid();
    emitGroup('{4'd0, 4'd0, 4'd15, 4'd15}, '{4'd15, 4'd15, 4'd0, 4'd0}, 0, 0);

    $display("[TB] backpressure on 4,8,6,2");
    applyStimulus('{4'd4, 4'd8, 4'd6, 4'd2}, 0, 1'b0);
    waitOutValid();
    emitGroup('{4'd2, 4'd4, 4'd6, 4'd8}, '{4'd8, 4'd6, 4'd4, 4'd2}, 3, 2);

    $display("[TB] input gaps on 12,1,11,2");
    applyStimulus('{4'd12, 4'd1, 4'd11, 4'd2}, 2, 1'b0);
    waitOutValid();
    emitGroup('{4'd1, 4'd2, 4'd11, 4'd12}, '{4'd12, 4'd11, 4'd2, 4'd1}, 0, 0);

    $display("[TB] reset in the middle of emit");
    applyStimulus('{4'd6, 4'd1, 4'd9, 4'd4}, 0, 1'b0);
    waitOutValid();
    out_ready = 1'b1;
    checkOutput("preRstData0", 32'(out_data), 32'd1);
    checkOutput("preRstDesc0", 32'(descOutData), 32'd9);
    tick();
    checkOutput("preRstData1", 32'(out_data), 32'd4);
    checkOutput("preRstDesc1", 32'(descOutData), 32'd6);
    tick();
    checkOutput("preRstStillValid", 32'(out_valid), 32'd1);
    nrst = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(out_valid), 32'd0);
    checkOutput("asyncRstReady", 32'(in_ready), 32'd1);
    checkOutput("asyncRstBusy", 32'(busy), 32'd0);
    checkOutput("asyncRstLast", 32'(out_last), 32'd0);
    checkOutput("asyncRstData", 32'(out_data), 32'd0);
    tick();
    nrst = 1'b1;
    tick();
    applyStimulus('{4'd3, 4'd2, 4'd1, 4'd0}, 0, 1'b0);
    waitOutValid();
    emitGroup('{4'd0, 4'd1, 4'd2, 4'd3}, '{4'd3, 4'd2, 4'd1, 4'd0}, 0, 0);

    $display("[TB] group 0,15,8,8 on both sort orders");
    applyStimulus('{4'd0, 4'd15, 4'd8, 4'd8}, 0, 1'b0);
    waitOutValid();
    emitGroup('{4'd0, 4'd8, 4'd8, 4'd15}, '{4'd15, 4'd8, 4'd8, 4'd0}, 0, 0);
    checkOutput("descIdleAtEnd", 32'(descBusy), 32'd0);
    checkOutput("descReadyAtEnd", 32'(descInReady), 32'd1);
    checkOutput("descValidAtEnd", 32'(descOutValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/serial_nibble_sorter.md
# serial_nibble_sorter

Sequential, stream-facing sorter for groups of four 4-bit values. It collects four nibbles over a valid/ready input stream and sorts them in place with a single compare-exchange unit stepped over five cycles. It then emits the result over a valid/ready output stream, smallest first. It is the serial-stream end of the team's four-element sorting datapath, for producers and consumers that move one nibble per cycle rather than a packed 16-bit word.

## Interface
- WIDTH, 4, bit width of each element.
- DESCEND, 0, sort order:
  - 0: output smallest first.
  - 1: output largest first.
- clk  input  1  clock; all state changes on the rising edge.
- nrst  input  1  reset, asynchronous and active-low.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  element to load.
- out_valid  output  1  out_data holds a sorted element.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  sorted element.
- out_last  output  1  high with the fourth (final) element of a group.
- busy  output  1  high whenever state is not LOAD.

## Operation
- Storage: four registers slot[0..3], a 2-bit load/emit index, and a 3-bit sort step counter.
- State LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, in_data is written to slot[idx] and idx increments.
  - The accept with idx==3 moves the block to SORT with step=0 and idx=0.
- State SORT:
  - in_ready=0, out_valid=0.
  - One compare-exchange per cycle, fixed order by step: 0:(0,2), 1:(1,3), 2:(0,1), 3:(2,3), 4:(1,2).
  - For pair (a,b) with DESCEND=0, swap only if slot[a] > slot[b] (strict, unsigned). With DESCEND=1, swap only if slot[a] < slot[b].
  - Equal values are never swapped.
  - After step 4 the block moves to EMIT with idx=0.
- State EMIT:
  - out_valid=1, out_data=slot[idx], out_last=(idx==3), in_ready=0.
  - On out_valid&&out_ready, idx increments.
  - The handshake with idx==3 moves the block to LOAD with idx=0.
- out_data and out_last are held stable while out_valid&&!out_ready.
- Inputs offered outside LOAD are not accepted (in_ready=0). The producer must hold them per valid/ready rules.
- Arithmetic: unsigned WIDTH-bit comparison only; no widening, no wrap concerns. The index wraps 3->0 only on the state transitions above.
- There are no other states. Any unreachable encoding recovers to LOAD on the next edge.

## Timing
- Reset (nrst=0, asynchronous): state=LOAD, idx=0, step=0, slot[*]=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
- Reset mid-group (in LOAD, SORT or EMIT) discards all loaded or sorted data. The next group starts from slot 0.
- in_ready, out_valid, out_last and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Latency:
  - Fourth input accepted at edge k.
  - SORT occupies the cycles after edges k..k+4.
  - out_valid rises after edge k+5, i.e. the first element appears 5 cycles after the last accept.
- Throughput, full streaming: 4 load + 5 sort + 4 emit = 13 cycles per group.
- in_ready rises in the cycle after the out_last handshake.
- A single-cycle in_valid pulse with no handshake has no effect.
- Back-to-back handshakes on consecutive cycles are required to be supported on both ports.

## Test plan
- Sort 9,3,7,1 (DESCEND=0), in_valid held high, out_ready held high:
  - Output 1,3,7,9, with out_last only on 9.
  - out_valid first high exactly 5 cycles after the accept of 1.
  - busy high from that accept until the out_last handshake.
- Duplicates 5,5,2,5: output 2,5,5,5.
- Group 0,0,0,0, then group 15,0,15,0: outputs 0,0,0,0 then 0,0,15,15.
- Backpressure, group 4,8,6,2 with out_ready low for 3 cycles at the first output and low for 2 cycles before out_last:
  - out_data held at 2, then at 8.
  - Full output 2,4,6,8.
  - in_ready stays 0 throughout.
- Input gaps, inputs 12,1,11,2 with 2 idle cycles between each:
  - Output 1,2,11,12.
  - in_ready low from the cycle after the 4th accept.
- Reset mid-EMIT: assert nrst low after two outputs have been accepted.
  - out_valid=0, in_ready=1, busy=0 immediately (asynchronously).
  - A new group 3,2,1,0 then sorts to 0,1,2,3.
- DESCEND=1, group 0,15,8,8: output 15,8,8,0.
